tdc_interval_builder: RTL and testbench

//  Consumes the fine bin numbers produced by the start and stop decoders.

---
 rtl/tdc_interval_builder.sv | 142 ++++++++++++++
 tb/tb_tdc_interval_builder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_interval_builder.sv
// Merges the start/stop fine bins with a coarse cycle count into one interval in delay bins,
// emitting one qualified result per start/stop pair.
module tdc_interval_builder #(
    parameter int BITS_DECO    = 8,
    parameter int COARSE_BITS  = 16,
    parameter int BINS_PER_CLK = 200,
    localparam int RES_BITS    = COARSE_BITS + BITS_DECO + 1
) (
    input  logic                wClk,
    input  logic                wRst,
    input  logic                wStartHit,
    input  logic [BITS_DECO-1:0] wStartBin,
    input  logic                wStopHit,
    input  logic [BITS_DECO-1:0] wStopBin,
    output logic [RES_BITS-1:0] wIntervalOut,
    output logic                wValidOut,
    input  logic                wReadyIn,
    output logic                wTimeoutOut,
    output logic                wErrOut,
    output logic                wBusyOut,
    output logic [7:0]          wDropCntOut,
    output logic [1:0]          state_dbg
);

    // Handshake: a result transfers on any rising edge where wValidOut & wReadyIn;
    // wValidOut, wIntervalOut and the flags do not change until that transfer.

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CALC = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [COARSE_BITS-1:0] CNT_LAST = {{(COARSE_BITS-1){1'b1}}, 1'b0};

    state_t                 state;
    logic [COARSE_BITS-1:0] cnt;
    logic [BITS_DECO-1:0]   start_bin;
    logic [BITS_DECO-1:0]   stop_bin;
    logic                   timeout;
    logic [RES_BITS-1:0]    result;
    logic                   result_err;
    logic                   result_to;

    logic [RES_BITS-1:0]    coarse_bins;
    logic [RES_BITS-1:0]    interval;
    logic                   calc_err;
    logic [1:0]             drops;
    logic [8:0]             drop_sum;

    assign state_dbg = state;
    assign wBusyOut  = (state != IDLE);

    // Interval is formed two's complement at RES_BITS; the top bit flags a negative result.
    always_comb begin
        coarse_bins = RES_BITS'(cnt) * RES_BITS'(BINS_PER_CLK);
        interval    = coarse_bins + RES_BITS'(start_bin) - RES_BITS'(stop_bin);
        calc_err    = (stop_bin == '0) || interval[RES_BITS-1];
    end

    // Every hit the FSM does not consume counts as one drop.
    always_comb begin
        drops = 2'd0;
        case (state)
            IDLE:    if (!(wStartHit && wStartBin != '0))
                         drops = {1'b0, wStartHit} + {1'b0, wStopHit};
            ARMED:   drops = {1'b0, wStartHit};
            default: drops = {1'b0, wStartHit} + {1'b0, wStopHit};
        endcase
        drop_sum = {1'b0, wDropCntOut} + {7'd0, drops};
    end

    always_ff @(posedge wClk) begin
        if (wRst) begin
            state        <= IDLE;
            cnt          <= '0;
            start_bin    <= '0;
            stop_bin     <= '0;
            timeout      <= 1'b0;
            result       <= '0;
            result_err   <= 1'b0;
            result_to    <= 1'b0;
            wIntervalOut <= '0;
            wValidOut    <= 1'b0;
            wTimeoutOut  <= 1'b0;
            wErrOut      <= 1'b0;
            wDropCntOut  <= '0;
        end else begin
            wDropCntOut <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (wStartHit && wStartBin != '0) begin
                        start_bin <= wStartBin;
                        cnt       <= '0;
                        timeout   <= 1'b0;
                        if (wStopHit) begin
                            stop_bin <= wStopBin;
                            state    <= CALC;
                        end else begin
                            stop_bin <= '0;
                            state    <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    // cnt+1 is the number of whole clocks elapsed at this edge.
                    cnt <= cnt + 1'b1;
                    if (wStopHit) begin
                        stop_bin <= wStopBin;
                        state    <= CALC;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    result_to  <= timeout;
                    result_err <= !timeout && calc_err;
                    if (timeout)
                        result <= '1;
                    else if (calc_err)
                        result <= '0;
                    else
                        result <= interval;
                    state <= HOLD;
                end
                HOLD: begin
                    if (!wValidOut) begin
                        wValidOut    <= 1'b1;
                        wIntervalOut <= result;
                        wTimeoutOut  <= result_to;
                        wErrOut      <= result_err;
                    end else if (wReadyIn) begin
                        wValidOut    <= 1'b0;
                        wIntervalOut <= '0;
                        wTimeoutOut  <= 1'b0;
                        wErrOut      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_interval_builder.sv
// Randomized start/stop transactions against an arithmetic interval model with a drop-count tally.
module tb_tdc_interval_builder;

    localparam int BITS_DECO    = 8;
    localparam int COARSE_BITS  = 4;
    localparam int BINS_PER_CLK = 200;
    localparam int RES_BITS     = COARSE_BITS + BITS_DECO + 1;
    localparam int W            = RES_BITS + 2;
    localparam int MAX_CYC      = (1 << COARSE_BITS) - 1;

    logic                 wClk = 1'b0;
    logic                 wRst;
    logic                 wStartHit;
    logic [BITS_DECO-1:0] wStartBin;
    logic                 wStopHit;
    logic [BITS_DECO-1:0] wStopBin;
    logic [RES_BITS-1:0]  wIntervalOut;
    logic                 wValidOut;
    logic                 wReadyIn;
    logic                 wTimeoutOut;
    logic                 wErrOut;
    logic                 wBusyOut;
    logic [7:0]           wDropCntOut;
    logic [1:0]           state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int exp_drops = 0;
    logic [W-1:0] exp_q[$];

    tdc_interval_builder #(
        .BITS_DECO(BITS_DECO), .COARSE_BITS(COARSE_BITS), .BINS_PER_CLK(BINS_PER_CLK)
    ) dut (
        .wClk(wClk), .wRst(wRst),
        .wStartHit(wStartHit), .wStartBin(wStartBin),
        .wStopHit(wStopHit), .wStopBin(wStopBin),
        .wIntervalOut(wIntervalOut), .wValidOut(wValidOut), .wReadyIn(wReadyIn),
        .wTimeoutOut(wTimeoutOut), .wErrOut(wErrOut), .wBusyOut(wBusyOut),
        .wDropCntOut(wDropCntOut), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 wClk = ~wClk;

    task automatic tick();
        @(posedge wClk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic count_drop();
        exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
    endtask

    task automatic clear_hits();
        wStartHit = 1'b0;
        wStopHit  = 1'b0;
        wStartBin = BITS_DECO'($urandom_range(0, 255));
        wStopBin  = BITS_DECO'($urandom_range(0, 255));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(wValidOut), 0);
        check_eq({tag, "_out"}, 32'(wIntervalOut), 0);
        check_eq({tag, "_err"}, 32'(wErrOut), 0);
        check_eq({tag, "_to"}, 32'(wTimeoutOut), 0);
        check_eq({tag, "_busy"}, 32'(wBusyOut), 0);
        check_eq({tag, "_drop"}, 32'(wDropCntOut), 0);
    endtask

    // One hit of either kind, while the FSM is busy and must ignore it.
    task automatic drive_busy_hit();
        if ($urandom_range(0, 1) == 0) begin
            wStartHit = 1'b1;
            wStartBin = BITS_DECO'($urandom_range(1, 255));
        end else begin
            wStopHit = 1'b1;
            wStopBin = BITS_DECO'($urandom_range(0, 255));
        end
        count_drop();
    endtask

    // Idle cycles with hits that cannot arm the FSM: lone stops and zero-bin starts.
    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: begin wStopHit = 1'b1; count_drop(); end
                1: begin wStartHit = 1'b1; wStartBin = '0; count_drop(); end
                default: ;
            endcase
            tick();
            clear_hits();
            check_eq("idle_busy", 32'(wBusyOut), 0);
            check_eq("idle_valid", 32'(wValidOut), 0);
        end
        check_eq("idle_drop", 32'(wDropCntOut), 32'(exp_drops));
    endtask

    // k = clocks from start to stop (0 = same cycle), k < 0 = no stop at all.
    task automatic run_pair(input int sb, input int pb, input int k, input int hold,
                            input bit noisy, input bit hold_pair);
        int ival;
        int stop_cyc;
        bit exp_to;
        bit exp_err;
        logic [RES_BITS-1:0] exp_out;
        logic [W-1:0] exp_word;

        exp_to  = (k < 0);
        ival    = k * BINS_PER_CLK + sb - pb;
        exp_err = !exp_to && (pb == 0 || ival < 0);
        exp_out = exp_to ? '1 : (exp_err ? '0 : RES_BITS'(ival));
        exp_q.push_back({exp_to, exp_err, exp_out});
        stop_cyc = exp_to ? MAX_CYC : k;

        wReadyIn  = 1'b0;
        wStartHit = 1'b1;
        wStartBin = BITS_DECO'(sb);
        if (k == 0) begin
            wStopHit = 1'b1;
            wStopBin = BITS_DECO'(pb);
        end
        tick();
        clear_hits();
        check_eq("start_busy", 32'(wBusyOut), 1);

        for (int c = 1; c <= stop_cyc; c++) begin
            if (c == stop_cyc && !exp_to) begin
                wStopHit = 1'b1;
                wStopBin = BITS_DECO'(pb);
            end
            if (noisy && $urandom_range(0, 3) == 0) begin
                wStartHit = 1'b1;
                wStartBin = BITS_DECO'($urandom_range(1, 255));
                count_drop();
            end
            tick();
            clear_hits();
            if (c < stop_cyc)
                check_eq("armed_busy", 32'(wBusyOut), 1);
        end

        // Two edges after the stop edge the result must be presented.
        for (int c = 0; c < 2; c++) begin
            wReadyIn = 1'($urandom_range(0, 1));
            if (noisy && $urandom_range(0, 1) == 0) drive_busy_hit();
            tick();
            clear_hits();
            if (c == 0) check_eq("lat_early", 32'(wValidOut), 0);
        end
        wReadyIn = 1'b0;

        exp_word = exp_q.pop_front();
        check_eq("valid", 32'(wValidOut), 1);
        check_eq("interval", 32'(wIntervalOut), 32'(exp_word[RES_BITS-1:0]));
        check_eq("err", 32'(wErrOut), 32'(exp_word[RES_BITS]));
        check_eq("timeout", 32'(wTimeoutOut), 32'(exp_word[RES_BITS+1]));

        for (int h = 0; h < hold; h++) begin
            if (hold_pair && h == 2) begin
                wStartHit = 1'b1; wStartBin = 8'd77; count_drop();
            end else if (hold_pair && h == 6) begin
                wStopHit = 1'b1; wStopBin = 8'd11; count_drop();
            end else if (noisy && $urandom_range(0, 2) == 0) begin
                drive_busy_hit();
            end
            tick();
            clear_hits();
            check_eq("hold_valid", 32'(wValidOut), 1);
            check_eq("hold_out", 32'({exp_word[RES_BITS+1:RES_BITS], wIntervalOut}),
                     32'({wTimeoutOut, wErrOut, exp_word[RES_BITS-1:0]}));
            check_eq("hold_flags", 32'({wTimeoutOut, wErrOut}), 32'(exp_word[RES_BITS+1:RES_BITS]));
        end

        // Accepting cycle; a start offered here must be ignored.
        wReadyIn = 1'b1;
        if (noisy && $urandom_range(0, 1) == 0) begin
            wStartHit = 1'b1;
            wStartBin = BITS_DECO'($urandom_range(1, 255));
            count_drop();
        end
        tick();
        clear_hits();
        wReadyIn = 1'b0;
        check_eq("accept_valid", 32'(wValidOut), 0);
        check_eq("accept_busy", 32'(wBusyOut), 0);
        check_eq("drop_cnt", 32'(wDropCntOut), 32'(exp_drops));
    endtask

    task automatic apply_reset(input string tag);
        wRst = 1'b1;
        tick();
        wRst = 1'b0;
        exp_drops = 0;
        exp_q.delete();
        check_all_zero(tag);
    endtask

    initial begin
        wRst = 1'b1;
        wReadyIn = 1'b0;
        clear_hits();
        tick();
        tick();
        wRst = 1'b0;
        check_all_zero("reset");

        // Zero-bin start stays idle and counts one drop.
        wStartHit = 1'b1;
        wStartBin = '0;
        count_drop();
        tick();
        clear_hits();
        check_eq("bin0_busy", 32'(wBusyOut), 0);
        check_eq("bin0_drop", 32'(wDropCntOut), 1);

        run_pair(50, 20, 3, 0, 1'b0, 1'b0);   // 630
        run_pair(80, 30, 0, 0, 1'b0, 1'b0);   // 50
        run_pair(30, 80, 0, 0, 1'b0, 1'b0);   // negative -> err
        run_pair(60, 0, 2, 0, 1'b0, 1'b0);    // stop bin 0 -> err
        run_pair(90, 0, -1, 1, 1'b0, 1'b0);   // timeout
        run_pair(50, 20, 3, 10, 1'b0, 1'b1);  // stall with two ignored hits
        run_pair(255, 1, MAX_CYC, 2, 1'b1, 1'b0);

        // Reset while armed: nothing emitted afterwards.
        wStartHit = 1'b1;
        wStartBin = 8'd40;
        tick();
        clear_hits();
        tick();
        apply_reset("rst_armed");
        wReadyIn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("rst_armed_quiet", 32'({wValidOut, wBusyOut}), 0);
        end

        // Reset while holding a result.
        wReadyIn  = 1'b0;
        wStartHit = 1'b1; wStartBin = 8'd100;
        wStopHit  = 1'b1; wStopBin  = 8'd10;
        tick();
        clear_hits();
        tick();
        tick();
        check_eq("pre_rst_valid", 32'(wValidOut), 1);
        apply_reset("rst_hold");
        wReadyIn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rst_hold_quiet", 32'({wValidOut, wBusyOut}), 0);
        end
        wReadyIn = 1'b0;

        for (int t = 0; t < 40; t++) begin
            int sb;
            int pb;
            int k;
            idle_noise($urandom_range(0, 3));
            sb = $urandom_range(1, 255);
            pb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            k  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, MAX_CYC);
            run_pair(sb, pb, k, $urandom_range(0, 4), 1'b1, 1'b0);
        end

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            wStopHit = 1'b1;
            count_drop();
            tick();
        end
        clear_hits();
        check_eq("drop_sat", 32'(wDropCntOut), 255);
        tick();
        check_eq("drop_sat_hold", 32'(wDropCntOut), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
